csr_encoder: RTL and testbench
==============================

Name: csr_encoder

Overview:
- Converts a dense, row-major matrix stream into CSR form: value array, column-index array and cumulative row-pointer array.
- Writes these arrays into the sparse-value, column and row-pointer RAMs that the CSR sparse-matrix multiplier later reads.
- It is the writer end of that memory interface.
- The row-pointer convention matches the multiplier's comparator: `row[0]=0`, and `row[r+1]` is the cumulative non-zero count after row r.

Parameters:
- `DATA_W`, 32: element width; also the width of the value RAM data.
- `N_ROWS`, 560: matrix rows.
- `N_COLS`, 560: matrix columns.
- `SP_AW`, 14: value/column RAM address width.
- `ROW_AW`, 10: row-pointer RAM address width; must satisfy N_ROWS+1 ≤ 2^ROW_AW.
- `NNZ_MAX`, 16384: capacity of the value/column RAMs.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins encoding one matrix.
- `in_valid` input 1: dense element present.
- `in_ready` output 1: encoder accepts an element.
- `in_data` input DATA_W: dense element value.
- `sp_we` output 1: write enable, shared by the value RAM and the column RAM.
- `sp_addr` output SP_AW: write address, shared by the value RAM and the column RAM.
- `sp_data` output DATA_W: non-zero value.
- `col_data` output 32: column index, zero-extended.
- `row_we` output 1: row-pointer RAM write enable.
- `row_addr` output ROW_AW: row-pointer RAM address.
- `row_data` output 32: cumulative non-zero count.
- `nnz_count` output 32: non-zeros stored so far; saturates at NNZ_MAX.
- `busy` output 1: high from INIT through STREAM.
- `done` output 1: one-cycle pulse when the matrix is complete.
- `overflow` output 1: sticky; more than NNZ_MAX non-zeros were seen.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs and internal counters are 0.
- Reset mid-operation aborts the encode. RAM contents are then undefined; the next start re-encodes from scratch.
- FSM:
  - IDLE → INIT on start. nnz_count and overflow clear on that edge.
  - INIT, one cycle: registers row_we=1, row_addr=0, row_data=0, with in_ready=0. Then INIT → STREAM.
  - STREAM: in_ready=1. An element is accepted on clk when in_valid & in_ready; no other cycle advances the counters.
  - After the final element is accepted, STREAM → DONE.
  - DONE, one cycle: done=1, in_ready=0, then DONE → IDLE.
- start is ignored outside IDLE.
- Row/column counters:
  - col increments per accepted element and wraps at N_COLS-1 back to 0, at which point row increments.
  - The final element is row=N_ROWS-1, col=N_COLS-1.
- Non-zero element (in_data≠0) with nnz<NNZ_MAX, on the next cycle:
  - sp_we=1, sp_addr=nnz, sp_data=in_data, col_data=col.
  - nnz increments.
- Non-zero element with nnz==NNZ_MAX:
  - No write is issued; overflow is set and nnz holds.
- Zero element: no value/column write.
- End of row (col==N_COLS-1 accepted), on the next cycle:
  - row_we=1, row_addr=row+1.
  - row_data = nnz including this element when it is non-zero (post-increment value).
  - This may coincide with sp_we; the two writes go to separate RAMs, so both occur in the same cycle.
- Write latency:
  - All RAM write outputs are registered and assert exactly one cycle after acceptance.
  - sp_we and row_we are single-cycle and deasserted otherwise.
  - sp_addr, sp_data, col_data, row_addr and row_data hold their last values when the write enable is low.
- done asserts in the cycle after the last row-pointer write.
- nnz_count is valid at done and holds until the next start.
- Throughput: one element per clock with in_valid held high. Bubbles in in_valid produce no writes.

Decomposition:
- Shared package `csr_pkg`:
  - Matrix dimensions 560/560.
  - SP_AW/ROW_AW/NNZ_MAX constants.
  - FSM state enum: IDLE, INIT, STREAM, DONE.
- Sub-module `csr_rc_counter`:
  - Row/column counter with enable, wrap at N_COLS-1, and flags `row_end` and `last`.

Test Plan:
1. N_ROWS=3, N_COLS=4, stream [5,0,0,7 / 0,0,0,0 / 0,9,0,0] with in_valid held high. Required:
   - sp writes (addr,val,col) = (0,5,0), (1,7,3), (2,9,1).
   - row writes (addr,data) = (0,0), (1,2), (2,2), (3,3).
   - done one cycle after row write (3,3); nnz_count=3; overflow=0.
2. Same matrix with in_valid toggled 1,0,1,0…: identical write sequence; no writes on bubble cycles; done is delayed accordingly.
3. All-zero 3x4 matrix: sp_we never asserts; row writes (0,0),(1,0),(2,0),(3,0); nnz_count=0.
4. NNZ_MAX=4, all-ones 3x4 matrix. Required:
   - sp writes at addr 0..3 only.
   - overflow=1 from the cycle after the 5th non-zero.
   - row writes (0,0),(1,4),(2,4),(3,4); nnz_count=4.
5. rst pulsed low after 6 accepted elements: all outputs 0 immediately and in_ready=0. A new start with matrix 1 reproduces test 1 exactly.
6. start pulsed during STREAM: no effect. After done, start in IDLE clears overflow (from test 4 state) and nnz_count to 0, then INIT writes (0,0).

Source files
------------

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants, FSM states and sizing helper for the CSR encoder
package csr_pkg;

   localparam int CSR_DATA_W  = 32;
   localparam int CSR_N_ROWS  = 560;
   localparam int CSR_N_COLS  = 560;
   localparam int CSR_SP_AW   = 14;
   localparam int CSR_ROW_AW  = 10;
   localparam int CSR_NNZ_MAX = 16384;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INIT   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } csr_state_e;

   // Counter width for a modulo-n count; never below one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/csr_rc_counter.sv
// rtl/csr_rc_counter.sv - row-major row/column position counter for the dense input stream
module csr_rc_counter
   import csr_pkg::*;
#(
   parameter int N_ROWS = CSR_N_ROWS,
   parameter int N_COLS = CSR_N_COLS,
   parameter int ROW_AW = CSR_ROW_AW,
   parameter int COL_W  = cnt_w(N_COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   output logic [ROW_AW-1:0] row,
   output logic [COL_W-1:0]  col,
   output logic              row_end,
   output logic              last
);

   logic [ROW_AW-1:0] row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;

   assign row     = row_q;
   assign col     = col_q;
   assign row_end = (col_q == COL_W'(N_COLS - 1));
   assign last    = row_end && (row_q == ROW_AW'(N_ROWS - 1));

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (en) begin
         if (row_end) begin
            col_d = '0;
            // After the final element both counters return to the origin.
            row_d = last ? '0 : row_q + ROW_AW'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/csr_encoder.sv
// rtl/csr_encoder.sv - dense row-major stream to CSR value/column/row-pointer RAM writer
module csr_encoder
   import csr_pkg::*;
#(
   parameter int DATA_W  = CSR_DATA_W,
   parameter int N_ROWS  = CSR_N_ROWS,
   parameter int N_COLS  = CSR_N_COLS,
   parameter int SP_AW   = CSR_SP_AW,
   parameter int ROW_AW  = CSR_ROW_AW,
   parameter int NNZ_MAX = CSR_NNZ_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              sp_we,
   output logic [SP_AW-1:0]  sp_addr,
   output logic [DATA_W-1:0] sp_data,
   output logic [31:0]       col_data,
   output logic              row_we,
   output logic [ROW_AW-1:0] row_addr,
   output logic [31:0]       row_data,
   output logic [31:0]       nnz_count,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   localparam int COL_W = cnt_w(N_COLS);

   csr_state_e        state_q, state_d;
   logic [31:0]       nnz_q, nnz_d;
   logic              overflow_q, overflow_d;
   logic              sp_we_q, sp_we_d;
   logic [SP_AW-1:0]  sp_addr_q, sp_addr_d;
   logic [DATA_W-1:0] sp_data_q, sp_data_d;
   logic [31:0]       col_data_q, col_data_d;
   logic              row_we_q, row_we_d;
   logic [ROW_AW-1:0] row_addr_q, row_addr_d;
   logic [31:0]       row_data_q, row_data_d;
   logic              done_q, done_d;

   logic              accept;
   logic              cnt_clr;
   logic              is_nz;
   logic              has_room;
   logic [31:0]       nnz_post;
   logic [ROW_AW-1:0] row;
   logic [COL_W-1:0]  col;
   logic              row_end;
   logic              last;

   assign in_ready = (state_q == STREAM);
   assign busy     = (state_q == INIT) || (state_q == STREAM);
   assign accept   = in_valid && in_ready;
   assign is_nz    = (in_data != '0);
   assign has_room = (nnz_q < 32'(NNZ_MAX));

   csr_rc_counter #(
      .N_ROWS (N_ROWS),
      .N_COLS (N_COLS),
      .ROW_AW (ROW_AW),
      .COL_W  (COL_W)
   ) u_rc (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (accept),
      .row     (row),
      .col     (col),
      .row_end (row_end),
      .last    (last)
   );

   always_comb begin
      state_d    = state_q;
      nnz_d      = nnz_q;
      overflow_d = overflow_q;
      sp_we_d    = 1'b0;
      sp_addr_d  = sp_addr_q;
      sp_data_d  = sp_data_q;
      col_data_d = col_data_q;
      row_we_d   = 1'b0;
      row_addr_d = row_addr_q;
      row_data_d = row_data_q;
      done_d     = 1'b0;
      cnt_clr    = 1'b0;
      nnz_post   = nnz_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = INIT;
               nnz_d      = '0;
               overflow_d = 1'b0;
               cnt_clr    = 1'b1;
               // Leading row pointer is written while sitting in INIT.
               row_we_d   = 1'b1;
               row_addr_d = '0;
               row_data_d = '0;
            end
         end
         INIT: begin
            state_d = STREAM;
         end
         STREAM: begin
            if (accept) begin
               if (is_nz) begin
                  if (has_room) begin
                     sp_we_d    = 1'b1;
                     sp_addr_d  = nnz_q[SP_AW-1:0];
                     sp_data_d  = in_data;
                     col_data_d = 32'(col);
                     nnz_post   = nnz_q + 32'd1;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               nnz_d = nnz_post;
               // Row pointer includes this element when it was stored.
               if (row_end) begin
                  row_we_d   = 1'b1;
                  row_addr_d = row + ROW_AW'(1);
                  row_data_d = nnz_post;
               end
               if (last) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         nnz_q      <= '0;
         overflow_q <= 1'b0;
         sp_we_q    <= 1'b0;
         sp_addr_q  <= '0;
         sp_data_q  <= '0;
         col_data_q <= '0;
         row_we_q   <= 1'b0;
         row_addr_q <= '0;
         row_data_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         nnz_q      <= nnz_d;
         overflow_q <= overflow_d;
         sp_we_q    <= sp_we_d;
         sp_addr_q  <= sp_addr_d;
         sp_data_q  <= sp_data_d;
         col_data_q <= col_data_d;
         row_we_q   <= row_we_d;
         row_addr_q <= row_addr_d;
         row_data_q <= row_data_d;
         done_q     <= done_d;
      end
   end

   assign sp_we     = sp_we_q;
   assign sp_addr   = sp_addr_q;
   assign sp_data   = sp_data_q;
   assign col_data  = col_data_q;
   assign row_we    = row_we_q;
   assign row_addr  = row_addr_q;
   assign row_data  = row_data_q;
   assign nnz_count = nnz_q;
   assign done      = done_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_csr_encoder.sv
// tb/tb_csr_encoder.sv - self-checking bench for csr_encoder on a 3x4 matrix with NNZ_MAX=4
module tb_csr_encoder;

   localparam int NR   = 3;
   localparam int NC   = 4;
   localparam int NE   = NR * NC;
   localparam int NMAX = 4;
   localparam int DW   = 32;
   localparam int SAW  = 14;
   localparam int RAW  = 10;

   logic           clk;
   logic           rst;
   logic           start;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic           sp_we;
   logic [SAW-1:0] sp_addr;
   logic [DW-1:0]  sp_data;
   logic [31:0]    col_data;
   logic           row_we;
   logic [RAW-1:0] row_addr;
   logic [31:0]    row_data;
   logic [31:0]    nnz_count;
   logic           busy;
   logic           done;
   logic           overflow;

   int checks = 0;
   int errors = 0;

   logic [95:0] sp_got[$];
   logic [95:0] row_got[$];
   int          row_cyc[$];
   int          done_cyc[$];
   int          bad_q[$];
   int          cyc = 0;
   logic        acc_prev = 1'b0;
   logic [31:0] mat [NE];

   csr_encoder #(
      .DATA_W  (DW),
      .N_ROWS  (NR),
      .N_COLS  (NC),
      .SP_AW   (SAW),
      .ROW_AW  (RAW),
      .NNZ_MAX (NMAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sp_we     (sp_we),
      .sp_addr   (sp_addr),
      .sp_data   (sp_data),
      .col_data  (col_data),
      .row_we    (row_we),
      .row_addr  (row_addr),
      .row_data  (row_data),
      .nnz_count (nnz_count),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   always @(posedge clk) acc_prev <= in_valid && in_ready;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (sp_we) begin
         sp_got.push_back({32'(sp_addr), sp_data, col_data});
         if (!acc_prev) bad_q.push_back(cyc);
      end
      if (row_we) begin
         row_got.push_back({32'd0, 32'(row_addr), row_data});
         row_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic outputs_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_nnz"}, nnz_count, 0);
      chk({tag, "_sp_we"}, sp_we, 0);
      chk({tag, "_sp_addr"}, sp_addr, 0);
      chk({tag, "_sp_data"}, sp_data, 0);
      chk({tag, "_col_data"}, col_data, 0);
      chk({tag, "_row_we"}, row_we, 0);
      chk({tag, "_row_addr"}, row_addr, 0);
      chk({tag, "_row_data"}, row_data, 0);
   endtask

   task automatic start_run();
      @(posedge clk);
      #1;
      sp_got.delete();
      row_got.delete();
      row_cyc.delete();
      done_cyc.delete();
      bad_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("init_in_ready", in_ready, 0);
      chk("init_busy", busy, 1);
      chk("init_nnz", nnz_count, 0);
      chk("init_overflow", overflow, 0);
      chk("init_row_we", row_we, 1);
      chk("init_row_addr", row_addr, 0);
      chk("init_row_data", row_data, 0);
   endtask

   // mode 0: valid held high, 1: alternating, 2: random bubbles
   task automatic feed(input int mode, input int mid_start, input int n);
      int idx = 0;
      int cl = 0;
      int nz;
      while (idx < n && cl < 400) begin
         @(negedge clk);
         nz = 0;
         for (int i = 0; i < idx; i++) if (mat[i] != 0) nz++;
         chk("run_nnz", nnz_count, (nz > NMAX) ? NMAX : nz);
         chk("run_overflow", overflow, (nz > NMAX) ? 1 : 0);
         start = (mid_start > 0) && (idx == mid_start);
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cl % 2 == 0);
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         in_data = mat[idx];
         if (in_valid && in_ready) idx++;
         cl++;
      end
      chk("feed_bound", idx, n);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      start    = 1'b0;
   endtask

   task automatic finish_run();
      logic [95:0] exp_sp[$];
      logic [95:0] exp_row[$];
      int nz = 0;
      int ov = 0;
      int w = 0;
      exp_row.push_back(96'd0);
      for (int i = 0; i < NE; i++) begin
         if (mat[i] != 0) begin
            if (nz < NMAX) begin
               exp_sp.push_back({32'(nz), mat[i], 32'(i % NC)});
               nz++;
            end else begin
               ov = 1;
            end
         end
         if (i % NC == NC - 1) exp_row.push_back({32'd0, 32'(i / NC + 1), 32'(nz)});
      end
      while (done !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("done_seen", done, 1);
      chk("done_nnz", nnz_count, nz);
      chk("done_overflow", overflow, ov);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 0);
      chk("done_count", done_cyc.size(), 1);
      if (done_cyc.size() > 0 && row_cyc.size() > 0)
         chk("done_after_row", done_cyc[0], row_cyc[row_cyc.size() - 1] + 1);
      chk("bubble_writes", bad_q.size(), 0);
      chk("sp_write_count", sp_got.size(), exp_sp.size());
      for (int i = 0; i < sp_got.size() && i < exp_sp.size(); i++)
         chk("sp_write", sp_got[i], exp_sp[i]);
      chk("row_write_count", row_got.size(), exp_row.size());
      for (int i = 0; i < row_got.size() && i < exp_row.size(); i++)
         chk("row_write", row_got[i], exp_row[i]);
      repeat (3) @(negedge clk);
      chk("nnz_hold", nnz_count, nz);
      chk("overflow_hold", overflow, ov);
   endtask

   task automatic set_mat1();
      mat = '{32'd5, 32'd0, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0};
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(negedge clk);
      #1;
      outputs_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      set_mat1();
      start_run();
      feed(0, 0, NE);
      finish_run();

      start_run();
      feed(1, 0, NE);
      finish_run();

      for (int i = 0; i < NE; i++) mat[i] = 32'd0;
      start_run();
      feed(0, 0, NE);
      finish_run();

      for (int i = 0; i < NE; i++) mat[i] = 32'd1;
      start_run();
      feed(0, 0, NE);
      finish_run();
      chk("overflow_sticky_idle", overflow, 1);

      set_mat1();
      start_run();
      feed(0, 5, NE);
      finish_run();

      start_run();
      feed(0, 0, 6);
      rst = 1'b0;
      #1;
      outputs_zero("midreset");
      @(negedge clk);
      rst = 1'b1;
      start_run();
      feed(0, 0, NE);
      finish_run();

      for (int r = 0; r < 8; r++) begin
         int dens;
         dens = $urandom_range(0, 4);
         for (int i = 0; i < NE; i++)
            mat[i] = ($urandom_range(0, 3) < dens) ? ($urandom | 32'h1) : 32'd0;
         start_run();
         feed(2, $urandom_range(0, NE - 1), NE);
         finish_run();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
